// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// controller state encoding and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR
  } lsu_state_e;

  // 011/110/111 carry funct3[1]=1 and so fall into the word class
  function automatic logic f3_is_word(input logic [2:0] f3);
    return f3[1] == F3_W[1];
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return f3[1:0] == F3_H[1:0];
  endfunction

  function automatic logic f3_is_byte(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0];
  endfunction

  function automatic logic f3_is_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and data-memory port of the load/store unit.
interface lsu_mem_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ready;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          store_done;
  logic          misalign_exc;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output ready, load_valid, load_data, store_done, misalign_exc,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  ready, load_valid, load_data, store_done, misalign_exc,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Selects the byte/half/word at the given offset of a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: BYTE_W];
    // offset[0] is ignored for halves: natural alignment within the word
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    if (f3_is_word(funct3_i))
      result_o = word_i;
    else if (f3_is_half(funct3_i))
      result_o = f3_is_unsigned(funct3_i) ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    else
      result_o = f3_is_unsigned(funct3_i) ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: one request at a time, sub-word loads
// extended, sub-word stores done as read-modify-write. LSU_MISALIGN_TRAP_EN enables misalignment traps.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);
  lsu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] ld_q, ld_d;
  logic          lv_q, lv_d, sd_q, sd_d, mis_q, mis_d;
  logic [DW-1:0] ext, merged;
  logic          misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (f3_is_half(bus.req_funct3) && bus.req_addr[0]) ||
                    (f3_is_word(bus.req_funct3) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_load_extend u_ext (
    .word_i   (bus.mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ext)
  );

  always_comb begin
    merged = bus.mem_rdata;
    if (f3_is_half(f3_q))
      merged[{off_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
    else
      merged[{off_q, 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    sd_d    = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (misalign) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = {bus.req_addr[AW-1:2], 2'b00};
            f3_d    = bus.req_funct3;
            off_d   = bus.req_addr[1:0];
            wdata_d = bus.req_wdata;
            if (!bus.req_we)                   state_d = S_LOAD;
            else if (f3_is_word(bus.req_funct3)) state_d = S_STORE;
            else                               state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        ld_d    = ext;
        lv_d    = 1'b1;
        state_d = S_IDLE;
      end
      S_STORE: begin
        sd_d    = 1'b1;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        sd_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      sd_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      sd_q    <= sd_d;
      mis_q   <= mis_d;
    end
  end

  // Write strobe comes from the state register alone, so reset kills it at once
  assign bus.ready        = (state_q == S_IDLE);
  assign bus.mem_we       = (state_q == S_STORE) || (state_q == S_RMW_WR);
  assign bus.mem_wdata    = (state_q == S_STORE)  ? wdata_q :
                            (state_q == S_RMW_WR) ? merge_q : '0;
  assign bus.mem_addr     = addr_q;
  assign bus.load_data    = ld_q;
  assign bus.load_valid   = lv_q;
  assign bus.store_done   = sd_q;
  assign bus.misalign_exc = mis_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: word memory environment, transaction-level reference
// model with per-cycle comparison, directed scenarios and randomized traffic.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.AW(32), .DW(32)) bus();
  lsu_mem_ctrl #(.AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  int n_chk = 0, n_fail = 0, we_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          rem = 0;
  bit          pend_st = 0;
  int          pend_idx = 0;
  logic [31:0] pend_new = 0, pend_ld = 0, exp_ld = 0;
  bit          exp_lv = 0, exp_sd = 0, exp_mis = 0;

  function automatic bit f_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1]) return off != 2'b00;
    if (f3[0]) return off[0];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    if (f3[1]) return w;
    if (f3[0]) begin
      s = w >> (16 * int'(off[1]));
      return f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    end
    s = w >> (8 * int'(off));
    return f3[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] old, input logic [2:0] f3,
                                          input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    if (f3[1]) return wd;
    r = old;
    if (f3[0]) r[16 * int'(off[1]) +: 16] = wd[15:0];
    else       r[8 * int'(off) +: 8]      = wd[7:0];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; pend_st <= 0; exp_lv <= 0; exp_sd <= 0; exp_mis <= 0; exp_ld <= '0;
    end else begin
      exp_lv <= 0; exp_sd <= 0; exp_mis <= 0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          if (pend_st) begin
            ref_mem[pend_idx] <= pend_new;
            exp_sd <= 1;
          end else begin
            exp_lv <= 1;
            exp_ld <= pend_ld;
          end
        end
      end else if (bus.req_valid) begin
        if (f_mis(bus.req_funct3, bus.req_addr[1:0])) begin
          exp_mis <= 1;
        end else if (!bus.req_we) begin
          pend_st <= 0;
          pend_ld <= f_load(ref_mem[bus.req_addr[7:2]], bus.req_funct3, bus.req_addr[1:0]);
          rem <= 1;
        end else begin
          pend_st  <= 1;
          pend_idx <= int'(bus.req_addr[7:2]);
          pend_new <= f_store(ref_mem[bus.req_addr[7:2]], bus.req_funct3,
                              bus.req_addr[1:0], bus.req_wdata);
          rem <= bus.req_funct3[1] ? 1 : 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("ready",        32'(bus.ready),        32'(rem == 0));
    check("load_valid",   32'(bus.load_valid),   32'(exp_lv));
    check("store_done",   32'(bus.store_done),   32'(exp_sd));
    check("misalign_exc", 32'(bus.misalign_exc), 32'(exp_mis));
    check("load_data",    bus.load_data,         exp_ld);
    check("mem_we",       32'(bus.mem_we),       32'(pend_st && rem == 1));
    if (pend_st && rem == 1) begin
      we_cycles++;
      check("mem_addr",  bus.mem_addr,  32'(pend_idx << 2));
      check("mem_wdata", bus.mem_wdata, pend_new);
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!bus.ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) check("accept_wait_ready", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!(bus.load_valid || bus.store_done || bus.misalign_exc) && lat < 10);
  endtask

  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int lat);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    wait_ready();
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_done(lat);
  endtask

  initial begin
    int lat, w0;
    logic [2:0] st_f3 [6];
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // reset state
    repeat (3) @(negedge clk);
    check("rst ready",     32'(bus.ready),  32'd1);
    check("rst mem_addr",  bus.mem_addr,    32'h0);
    check("rst mem_wdata", bus.mem_wdata,   32'h0);
    check("rst mem_we",    32'(bus.mem_we), 32'd0);
    check("rst load_data", bus.load_data,   32'h0);
    #2 rst_n = 1;

    // sub-word loads
    preload(32'h40 >> 2, 32'h8899AABB);
    send(0, 3'b000, 32'h41, 0, lat); check("LB 0x41", bus.load_data, 32'hFFFFFFAA); check("LB lat", 32'(lat), 32'd2);
    send(0, 3'b100, 32'h41, 0, lat); check("LBU 0x41", bus.load_data, 32'h000000AA); check("LBU lat", 32'(lat), 32'd2);
    send(0, 3'b001, 32'h42, 0, lat); check("LH 0x42", bus.load_data, 32'hFFFF8899); check("LH lat", 32'(lat), 32'd2);
    send(0, 3'b010, 32'h40, 0, lat); check("LW 0x40", bus.load_data, 32'h8899AABB); check("LW lat", 32'(lat), 32'd2);

    // word store then read back
    w0 = we_cycles;
    send(1, 3'b010, 32'h10, 32'h12345678, lat);
    check("SW lat", 32'(lat), 32'd2); check("SW we cycles", 32'(we_cycles - w0), 32'd1);
    check("SW mem", mem[4], 32'h12345678);
    send(0, 3'b010, 32'h10, 0, lat); check("LW 0x10", bus.load_data, 32'h12345678);

    // read-modify-write
    preload(32'h20 >> 2, 32'h11223344);
    w0 = we_cycles;
    send(1, 3'b000, 32'h23, 32'h000000EE, lat);
    check("SB lat", 32'(lat), 32'd3); check("SB we cycles", 32'(we_cycles - w0), 32'd1);
    check("SB mem", mem[8], 32'hEE223344);
    w0 = we_cycles;
    send(1, 3'b001, 32'h20, 32'h0000BEEF, lat);
    check("SH lat", 32'(lat), 32'd3); check("SH we cycles", 32'(we_cycles - w0), 32'd1);
    check("SH mem", mem[8], 32'hEE22BEEF);

    // back-to-back SB then LBU with req_valid held throughout
    preload(32'h24 >> 2, 32'h01020304);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h25; bus.req_wdata = 32'hA5;
    wait_ready();
    @(posedge clk); #1;
    bus.req_we = 0; bus.req_funct3 = 3'b100;
    wait_done(lat);
    check("b2b SB done", 32'(bus.store_done), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_done(lat);
    check("b2b LBU data", bus.load_data, 32'h000000A5);
    check("b2b LBU lat", 32'(lat), 32'd2);

    // reset during RMW_RD
    preload(32'h30 >> 2, 32'hAAAAAAAA);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h30; bus.req_wdata = 32'h55;
    wait_ready();
    @(posedge clk); #1;
    bus.req_valid = 0;
    #2 rst_n = 0;
    check("rst mid mem_we", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst mid ready", 32'(bus.ready), 32'd1);
    check("rst mid mem", mem[12], 32'hAAAAAAAA);

    // misaligned word load
    w0 = we_cycles;
    send(0, 3'b010, 32'h41, 0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis pulse", 32'(bus.misalign_exc), 32'd1);
    check("mis lat", 32'(lat), 32'd1);
    check("mis no lv", 32'(bus.load_valid), 32'd0);
    check("mis no we", 32'(we_cycles - w0), 32'd0);
`else
    check("LW 0x41 data", bus.load_data, 32'h8899AABB);
    check("LW 0x41 lat", 32'(lat), 32'd2);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit          we  = 1'($urandom_range(0, 1));
      logic [2:0]  f3  = we ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      logic [31:0] a   = 32'($urandom_range(0, 255));
      int          exp_lat = f_mis(f3, a[1:0]) ? 1 : (we && !f3[1]) ? 3 : 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(we, f3, a, $urandom, lat);
      check("rand lat", 32'(lat), 32'(exp_lat));
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) check("final mem", mem[i], ref_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
